// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per clock from the MSB
// and stops at the first differing chunk. Result is one-hot {gt,lt,eq} with rdy/done.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       out,
  output logic             rdy,
  output logic             done
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NPAD = 1 << IW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q, a_n, b_n;
  logic             sgn_q, sgn_n;
  logic [IW-1:0]    idx, idx_n;
  logic [2:0]       out_n;
  logic             rdy_n, done_n;

  logic [CHUNK-1:0] a_ch [NPAD];
  logic [CHUNK-1:0] b_ch [NPAD];
  logic [CHUNK-1:0] ca, cb;

  // Chunk table padded to a power of two so any idx value selects a defined entry.
  for (genvar gi = 0; gi < NPAD; gi++) begin : g_chunk
    if (gi < NCH) begin : g_live
      assign a_ch[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_ch[gi] = b_q[gi*CHUNK +: CHUNK];
    end else begin : g_pad
      assign a_ch[gi] = '0;
      assign b_ch[gi] = '0;
    end
  end

  // Flipping the sign bits of the top chunk turns a two's-complement compare into an unsigned one.
  always_comb begin
    ca = a_ch[idx];
    cb = b_ch[idx];
    if (sgn_q && (idx == IW'(NCH - 1))) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    sgn_n   = sgn_q;
    idx_n   = idx;
    out_n   = out;
    case (state)
      IDLE, DONE: begin
        if (cs) begin
          a_n     = a;
          b_n     = b;
          sgn_n   = signed_mode;
          idx_n   = IW'(NCH - 1);
          out_n   = 3'b000;
          state_n = COMPARE;
        end else begin
          state_n = IDLE;
        end
      end
      COMPARE: begin
        if (ca > cb) begin
          out_n   = 3'b100;
          state_n = DONE;
        end else if (ca < cb) begin
          out_n   = 3'b010;
          state_n = DONE;
        end else if (idx == '0) begin
          out_n   = 3'b001;
          state_n = DONE;
        end else begin
          idx_n = idx - IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    rdy_n  = (state_n != COMPARE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      idx   <= IW'(NCH - 1);
      out   <= 3'b000;
      rdy   <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      a_q   <= a_n;
      b_q   <= b_n;
      sgn_q <= sgn_n;
      idx   <= idx_n;
      out   <= out_n;
      rdy   <= rdy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator: a 16/4 instance and an 8/8 instance,
// directed cases plus random sweeps checked against an integer reference model.
module tb_seq_magnitude_comparator;

  typedef struct {
    logic [2:0] o;
    int         lat;
    int         acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs16 = 1'b0, sm16 = 1'b0, cs8 = 1'b0, sm8 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  out16, out8;
  logic        rdy16, done16, rdy8, done8;

  int   total = 0, bad = 0, cyc = 0;
  int   issued16 = 0, issued8 = 0, dones16 = 0, dones8 = 0;
  exp_t q16[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .cs(cs16), .signed_mode(sm16),
    .a(a16), .b(b16), .out(out16), .rdy(rdy16), .done(done16)
  );

  seq_magnitude_comparator #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .cs(cs8), .signed_mode(sm8),
    .a(a8), .b(b8), .out(out8), .rdy(rdy8), .done(done8)
  );

  function automatic logic [2:0] ref_out(int unsigned av, int unsigned bv, bit sg, int w);
    longint sa = longint'(av);
    longint sb = longint'(bv);
    if (sg && av[w-1]) sa = sa - (longint'(1) << w);
    if (sg && bv[w-1]) sb = sb - (longint'(1) << w);
    if (sa > sb) return 3'b100;
    if (sa < sb) return 3'b010;
    return 3'b001;
  endfunction

  // Edges from accept to DONE: one more than the number of leading equal chunks, capped at NCH.
  function automatic int ref_lat(int unsigned av, int unsigned bv, int w, int ch);
    int unsigned x = av ^ bv;
    int p = -1;
    for (int i = 0; i < w; i++) if (x[i]) p = i;
    if (p < 0) return w / ch;
    return w / ch - p / ch;
  endfunction

  task automatic chk(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_n && done16) begin
      dones16++;
      if (q16.size() == 0) begin
        total++; bad++;
        $display("FAIL done16_unexpected: got out=%b expected no done", out16);
      end else begin
        e = q16.pop_front();
        chk("out16", int'(out16), int'(e.o));
        chk("lat16", cyc - e.acc, e.lat);
        chk("rdy16_at_done", int'(rdy16), 1);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && done8) begin
      dones8++;
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL done8_unexpected: got out=%b expected no done", out8);
      end else begin
        e = q8.pop_front();
        chk("out8", int'(out8), int'(e.o));
        chk("lat8", cyc - e.acc, e.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the DONE cycle. With hold, cs stays high
  // so the following call is accepted on the DONE edge.
  task automatic issue(bit w8, logic [15:0] av, logic [15:0] bv, bit sg, bit hold);
    exp_t e;
    int n;
    if (!hold) begin
      if (w8) cs8 = 1'b0; else cs16 = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n = 0;
    while (!(w8 ? rdy8 : rdy16) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL rdy_timeout: got rdy=0 expected rdy=1 within 100 cycles");
      return;
    end
    e.acc = cyc + 1;
    if (w8) begin
      a8 = av[7:0]; b8 = bv[7:0]; sm8 = sg; cs8 = 1'b1;
      e.o   = ref_out(32'(av[7:0]), 32'(bv[7:0]), sg, 8);
      e.lat = ref_lat(32'(av[7:0]), 32'(bv[7:0]), 8, 8);
      q8.push_back(e);
      issued8++;
    end else begin
      a16 = av; b16 = bv; sm16 = sg; cs16 = 1'b1;
      e.o   = ref_out(32'(av), 32'(bv), sg, 16);
      e.lat = ref_lat(32'(av), 32'(bv), 16, 4);
      q16.push_back(e);
      issued16++;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (w8 ? rdy8 : rdy16) break;
      n++;
      if (n > 100) begin
        total++; bad++;
        $display("FAIL done_timeout: got rdy=0 expected rdy=1 within 100 cycles");
        break;
      end
      // Scribble over the inputs while the compare is in flight.
      if (w8) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        cs8 = hold ? 1'b1 : 1'($urandom);
      end else begin
        a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
        cs16 = hold ? 1'b1 : 1'($urandom);
      end
    end
    if (!hold) begin
      if (w8) cs8 = 1'b0; else cs16 = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q16.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q16", q16.size(), 0);
    chk("drain_q8", q8.size(), 0);
  endtask

  function automatic logic [15:0] near16(logic [15:0] x);
    logic [15:0] m = 16'($urandom);
    return x ^ (m >> $urandom_range(0, 16));
  endfunction

  initial begin
    logic [15:0] ra;
    repeat (3) @(negedge clk);
    chk("rst_out16", int'(out16), 0);
    chk("rst_rdy16", int'(rdy16), 1);
    chk("rst_done16", int'(done16), 0);
    chk("rst_rdy8", int'(rdy8), 1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 16'h1234, 16'h1234, 0, 0);
    issue(0, 16'h8000, 16'h7FFF, 0, 0);
    issue(0, 16'h8000, 16'h7FFF, 1, 0);
    issue(0, 16'h12F4, 16'h12F5, 1, 0);
    issue(0, 16'hFFFF, 16'h0001, 1, 0);
    issue(0, 16'h7FFF, 16'h8000, 1, 0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      issue(0, ra, near16(ra), 1'($urandom), 1);
    end
    cs16 = 1'b0;
    drain();

    @(negedge clk);
    a16 = 16'h5A5A; b16 = 16'h5A5A; sm16 = 1'b0; cs16 = 1'b1;
    @(posedge clk);
    #1 cs16 = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_rdy16", int'(rdy16), 1);
    chk("midrst_out16", int'(out16), 0);
    chk("midrst_done16", int'(done16), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("postrst_rdy16", int'(rdy16), 1);

    issue(1, 16'h0005, 16'h0005, 0, 0);
    issue(1, 16'h0080, 16'h007F, 1, 0);
    for (int i = 0; i < 100; i++)
      issue(1, 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom), 1'($urandom));
    cs8 = 1'b0;
    drain();

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      issue(0, ra, near16(ra), 1'($urandom), 1'($urandom));
    end
    cs16 = 1'b0;
    drain();

    repeat (4) @(negedge clk);
    chk("dones16_per_request", dones16, issued16);
    chk("dones8_per_request", dones8, issued8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
